// File: rtl/chess_pkg.sv
// Shared chess encodings for the position bus: piece codes, square indexing,
// the start position and castle-right bit positions.
package chess_pkg;

  localparam int unsigned NSQ      = 64;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned SQ_W     = 6;
  localparam int unsigned RF_W     = 3;
  localparam int unsigned MOVE_W   = 20;
  localparam int unsigned CASTLE_W = 4;

  typedef enum logic [2:0] {
    PC_NONE   = 3'd0,
    PC_KING   = 3'd1,
    PC_QUEEN  = 3'd2,
    PC_ROOK   = 3'd3,
    PC_BISHOP = 3'd4,
    PC_KNIGHT = 3'd5,
    PC_PAWN   = 3'd6
  } piece_e;

  localparam int unsigned COLOR_BIT = 3;

  localparam int unsigned CASTLE_WK = 3;
  localparam int unsigned CASTLE_WQ = 2;
  localparam int unsigned CASTLE_BK = 1;
  localparam int unsigned CASTLE_BQ = 0;

  localparam logic [SQ_W-1:0] SQ_A1 = 6'd0;
  localparam logic [SQ_W-1:0] SQ_H1 = 6'd7;
  localparam logic [SQ_W-1:0] SQ_A8 = 6'd56;
  localparam logic [SQ_W-1:0] SQ_H8 = 6'd63;

  typedef logic [NSQ-1:0][NIB_W-1:0] board_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]      promote;
    logic [2:0]      piece;
    logic [RF_W-1:0] from_r;
    logic [RF_W-1:0] from_f;
    logic [2:0]      takes;
    logic [RF_W-1:0] to_r;
    logic [RF_W-1:0] to_f;
  } move_t;

  // Square 63 (h8) is the leftmost nibble, square 0 (a1) the rightmost.
  localparam board_t START_POS =
    256'h35412453_66666666_00000000_00000000_00000000_00000000_EEEEEEEE_BDC9ACDB;

  function automatic logic [SQ_W-1:0] rankfile(input logic [RF_W-1:0] r,
                                               input logic [RF_W-1:0] f);
    return {r, f};
  endfunction

  function automatic piece_e promo_piece(input logic [1:0] p);
    case (p)
      2'd0:    return PC_QUEEN;
      2'd1:    return PC_BISHOP;
      2'd2:    return PC_ROOK;
      default: return PC_KNIGHT;
    endcase
  endfunction

endpackage

// File: rtl/board_pos_tx_if.sv
// Host strobes plus the outgoing serial position bus of board_pos_tx.
interface board_pos_tx_if;
  import chess_pkg::*;

  logic              i_init;
  logic              i_move_valid;
  logic [MOVE_W-1:0] i_move_data;
  logic              i_send;
  logic              o_busy;
  logic              out_pos_valid;
  logic [NIB_W-1:0]  out_pos_data;
  logic              out_pos_sop;
  logic              out_pos_eop;
  logic              out_wtp;
  logic [CASTLE_W-1:0] out_castle;
  logic              out_ep_valid;
  logic [RF_W-1:0]   out_ep;

  modport master (
    output i_init, i_move_valid, i_move_data, i_send,
    input  o_busy, out_pos_valid, out_pos_data, out_pos_sop, out_pos_eop,
           out_wtp, out_castle, out_ep_valid, out_ep
  );

  modport slave (
    input  i_init, i_move_valid, i_move_data, i_send,
    output o_busy, out_pos_valid, out_pos_data, out_pos_sop, out_pos_eop,
           out_wtp, out_castle, out_ep_valid, out_ep
  );
endinterface

// File: rtl/board_move_apply.sv
// Combinational next-position function: applies one UCI move to the board,
// including promotion, castling rook hop, en-passant capture and rights update.
module board_move_apply
  import chess_pkg::*;
(
  input  board_t              board,
  input  logic                wtp,
  input  logic [CASTLE_W-1:0] castle,
  input  move_t               move,
  output board_t              next_board_c,
  output logic [CASTLE_W-1:0] next_castle_c,
  output logic                next_ep_valid_c,
  output logic [RF_W-1:0]     next_ep_c
);

  logic [SQ_W-1:0]  from_idx;
  logic [SQ_W-1:0]  to_idx;
  logic [NIB_W-1:0] mover;
  logic [RF_W-1:0]  home_r;
  logic             is_pawn;
  logic             is_king;
  logic             to_empty;
  logic             promote_now;
  logic             two_rank;
  logic             unused_fields;

  assign from_idx    = rankfile(move.from_r, move.from_f);
  assign to_idx      = rankfile(move.to_r, move.to_f);
  assign mover       = board[from_idx];
  assign is_pawn     = (piece_e'(mover[2:0]) == PC_PAWN);
  assign is_king     = (piece_e'(mover[2:0]) == PC_KING);
  assign home_r      = wtp ? 3'd0 : 3'd7;
  assign to_empty    = (board[to_idx] == '0);
  assign promote_now = is_pawn && (move.to_r == (wtp ? 3'd7 : 3'd0));
  assign two_rank    = is_pawn &&
                       (({1'b0, move.to_r} == 4'({1'b0, move.from_r} + 4'd2)) ||
                        ({1'b0, move.from_r} == 4'({1'b0, move.to_r} + 4'd2)));
  // The board decides what moves; the host's piece/takes hints are not needed.
  assign unused_fields = ^{move.piece, move.takes};

  always_comb begin : board_update
    next_board_c = board;
    if (is_pawn && (move.from_f != move.to_f) && to_empty) begin
      next_board_c[rankfile(move.from_r, move.to_f)] = '0;
    end
    if (is_king && (move.from_f == 3'd4) && (move.to_f == 3'd6)) begin
      next_board_c[rankfile(home_r, 3'd5)] = board[rankfile(home_r, 3'd7)];
      next_board_c[rankfile(home_r, 3'd7)] = '0;
    end
    if (is_king && (move.from_f == 3'd4) && (move.to_f == 3'd2)) begin
      next_board_c[rankfile(home_r, 3'd3)] = board[rankfile(home_r, 3'd0)];
      next_board_c[rankfile(home_r, 3'd0)] = '0;
    end
    next_board_c[from_idx] = '0;
    next_board_c[to_idx]   = promote_now ? {mover[COLOR_BIT], promo_piece(move.promote)}
                                         : mover;
  end

  always_comb begin : castle_update
    next_castle_c = castle;
    if (is_king && wtp) begin
      next_castle_c[CASTLE_WK] = 1'b0;
      next_castle_c[CASTLE_WQ] = 1'b0;
    end
    if (is_king && !wtp) begin
      next_castle_c[CASTLE_BK] = 1'b0;
      next_castle_c[CASTLE_BQ] = 1'b0;
    end
    if ((from_idx == SQ_A1) || (to_idx == SQ_A1)) next_castle_c[CASTLE_WQ] = 1'b0;
    if ((from_idx == SQ_H1) || (to_idx == SQ_H1)) next_castle_c[CASTLE_WK] = 1'b0;
    if ((from_idx == SQ_A8) || (to_idx == SQ_A8)) next_castle_c[CASTLE_BQ] = 1'b0;
    if ((from_idx == SQ_H8) || (to_idx == SQ_H8)) next_castle_c[CASTLE_BK] = 1'b0;
  end

  assign next_ep_valid_c = two_rank;
  assign next_ep_c       = two_rank ? move.from_f : 3'd0;

endmodule

// File: rtl/board_pos_tx.sv
// Board-state holder: applies moves and streams the board as 64 FEN-ordered
// nibbles with sop/eop on the position bus.
module board_pos_tx
  import chess_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  board_pos_tx_if.slave  bus
);

  state_e              state_q, state_d;
  board_t              board_q;
  logic                wtp_q;
  logic [CASTLE_W-1:0] castle_q;
  logic                ep_valid_q;
  logic [RF_W-1:0]     ep_q;
  move_t               move_q;
  logic [SQ_W-1:0]     cnt_q;
  logic                busy_q;
  logic                valid_q;
  logic [NIB_W-1:0]    data_q;
  logic                sop_q;
  logic                eop_q;

  logic                do_init_c;
  logic                take_move_c;
  logic                commit_c;
  logic                beat_c;

  board_t              next_board_c;
  logic [CASTLE_W-1:0] next_castle_c;
  logic                next_ep_valid_c;
  logic [RF_W-1:0]     next_ep_c;

  board_move_apply u_apply (
    .board           (board_q),
    .wtp             (wtp_q),
    .castle          (castle_q),
    .move            (move_q),
    .next_board_c    (next_board_c),
    .next_castle_c   (next_castle_c),
    .next_ep_valid_c (next_ep_valid_c),
    .next_ep_c       (next_ep_c)
  );

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // init wins over move, move over send; init completes without leaving IDLE
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_init)            state_d = ST_IDLE;
        else if (bus.i_move_valid) state_d = ST_MOVE;
        else if (bus.i_send)       state_d = ST_SEND;
      end
      ST_MOVE: state_d = ST_IDLE;
      ST_SEND: if (cnt_q == 6'd63) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : fsm_outputs
    do_init_c   = 1'b0;
    take_move_c = 1'b0;
    commit_c    = 1'b0;
    beat_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        do_init_c   = bus.i_init;
        take_move_c = !bus.i_init && bus.i_move_valid;
      end
      ST_MOVE: commit_c = 1'b1;
      ST_SEND: beat_c   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : datapath
    if (rst) begin
      board_q    <= START_POS;
      wtp_q      <= 1'b1;
      castle_q   <= 4'hF;
      ep_valid_q <= 1'b0;
      ep_q       <= '0;
      move_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= beat_c;
      sop_q   <= beat_c && (cnt_q == 6'd0);
      eop_q   <= beat_c && (cnt_q == 6'd63);
      // Beat k shows rank 7-k/8, file k%8; inverting the rank bits gives 7-k/8.
      data_q  <= beat_c ? board_q[rankfile(~cnt_q[5:3], cnt_q[2:0])] : '0;
      cnt_q   <= beat_c ? 6'(cnt_q + 6'd1) : '0;
      if (take_move_c) move_q <= move_t'(bus.i_move_data);
      if (do_init_c) begin
        board_q    <= START_POS;
        wtp_q      <= 1'b1;
        castle_q   <= 4'hF;
        ep_valid_q <= 1'b0;
        ep_q       <= '0;
      end else if (commit_c) begin
        board_q    <= next_board_c;
        wtp_q      <= !wtp_q;
        castle_q   <= next_castle_c;
        ep_valid_q <= next_ep_valid_c;
        ep_q       <= next_ep_c;
      end
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.out_pos_valid = valid_q;
  assign bus.out_pos_data  = data_q;
  assign bus.out_pos_sop   = sop_q;
  assign bus.out_pos_eop   = eop_q;
  assign bus.out_wtp       = wtp_q;
  assign bus.out_castle    = castle_q;
  assign bus.out_ep_valid  = ep_valid_q;
  assign bus.out_ep        = ep_q;

endmodule

// File: tb/tb_board_pos_tx.sv
// Bench for board_pos_tx: directed scenarios plus random moves/sends checked
// against a rank/file board model.
module tb_board_pos_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_pos_tx_if bus();

  board_pos_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference position, indexed [rank][file]
  logic [3:0] bd [8][8];
  logic       m_wtp;
  logic [3:0] m_castle;
  logic       m_epv;
  int         m_ep;
  logic [3:0] beat_q [64];

  function automatic void model_init();
    int back [8] = '{3, 5, 4, 2, 1, 4, 5, 3};
    for (int r = 0; r < 8; r++)
      for (int f = 0; f < 8; f++) bd[r][f] = 4'h0;
    for (int f = 0; f < 8; f++) begin
      bd[0][f] = 4'(8 + back[f]);
      bd[1][f] = 4'hE;
      bd[6][f] = 4'h6;
      bd[7][f] = 4'(back[f]);
    end
    m_wtp = 1'b1; m_castle = 4'hF; m_epv = 1'b0; m_ep = 0;
  endfunction

  function automatic void model_move(input int fr, input int ff, input int tr, input int tf, input int promo);
    int pp [4] = '{2, 4, 3, 5};
    logic [3:0] p = bd[fr][ff];
    int  kind = int'(p[2:0]);
    int  home = m_wtp ? 0 : 7;
    bit  pawn = (kind == 6);
    bit  king = (kind == 1);
    bit  dest_empty = (bd[tr][tf] == 4'h0);
    int  dr = (tr > fr) ? tr - fr : fr - tr;
    if (pawn && ff != tf && dest_empty) bd[fr][tf] = 4'h0;
    if (king && ff == 4 && tf == 6) begin bd[home][5] = bd[home][7]; bd[home][7] = 4'h0; end
    if (king && ff == 4 && tf == 2) begin bd[home][3] = bd[home][0]; bd[home][0] = 4'h0; end
    bd[fr][ff] = 4'h0;
    if (pawn && tr == (m_wtp ? 7 : 0)) bd[tr][tf] = {p[3], 3'(pp[promo])};
    else                               bd[tr][tf] = p;
    if (king) begin
      if (m_wtp) m_castle[3:2] = 2'b00;
      else       m_castle[1:0] = 2'b00;
    end
    if ((fr == 0 && ff == 0) || (tr == 0 && tf == 0)) m_castle[2] = 1'b0;
    if ((fr == 0 && ff == 7) || (tr == 0 && tf == 7)) m_castle[3] = 1'b0;
    if ((fr == 7 && ff == 0) || (tr == 7 && tf == 0)) m_castle[0] = 1'b0;
    if ((fr == 7 && ff == 7) || (tr == 7 && tf == 7)) m_castle[1] = 1'b0;
    m_epv = pawn && (dr == 2);
    m_ep  = m_epv ? ff : 0;
    m_wtp = !m_wtp;
  endfunction

  function automatic logic [19:0] enc(input int fr, input int ff, input int tr, input int tf, input int promo);
    return {2'(promo), 3'd0, 3'(fr), 3'(ff), 3'd0, 3'(tr), 3'(tf)};
  endfunction

  task automatic check_flags(input string tag);
    check({tag, "_wtp"}, bus.out_wtp, m_wtp);
    check({tag, "_castle"}, bus.out_castle, m_castle);
    check({tag, "_epv"}, bus.out_ep_valid, m_epv);
    if (m_epv) check({tag, "_ep"}, bus.out_ep, 32'(m_ep));
  endtask

  task automatic do_move(input int fr, input int ff, input int tr, input int tf, input int promo);
    @(negedge clk);
    bus.i_move_valid = 1'b1;
    bus.i_move_data  = enc(fr, ff, tr, tf, promo);
    @(posedge clk);
    @(negedge clk);
    bus.i_move_valid = 1'b0;
    check("move_busy", bus.o_busy, 1);
    model_move(fr, ff, tr, tf, promo);
    @(negedge clk);
    check("move_done_busy", bus.o_busy, 0);
    check_flags("move");
  endtask

  task automatic do_init();
    @(negedge clk);
    bus.i_init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_init = 1'b0;
    model_init();
    check("init_busy", bus.o_busy, 0);
    check_flags("init");
  endtask

  // Streams the board; optionally injects a move strobe or a reset at a beat.
  task automatic send_check(input string tag, input int inject_at, input int rst_at);
    bit aborted = 1'b0;
    @(negedge clk);
    bus.i_send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_send = 1'b0;
    check({tag, "_busy"}, bus.o_busy, 1);
    check({tag, "_latency"}, bus.out_pos_valid, 0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      bus.i_move_valid = 1'b0;
      beat_q[k] = bus.out_pos_data;
      check($sformatf("%s_d%0d", tag, k), bus.out_pos_data, bd[7 - k / 8][k % 8]);
      check($sformatf("%s_v%0d", tag, k), bus.out_pos_valid, 1);
      check($sformatf("%s_sop%0d", tag, k), bus.out_pos_sop, (k == 0));
      check($sformatf("%s_eop%0d", tag, k), bus.out_pos_eop, (k == 63));
      if (k % 16 == 5) check_flags($sformatf("%s_f%0d", tag, k));
      if (k == inject_at) begin
        bus.i_move_valid = 1'b1;
        bus.i_move_data  = enc(6, 3, 4, 3, 0);
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_valid"}, bus.out_pos_valid, 0);
        check({tag, "_rst_eop"}, bus.out_pos_eop, 0);
        check({tag, "_rst_busy"}, bus.o_busy, 0);
        check({tag, "_rst_data"}, bus.out_pos_data, 0);
        check({tag, "_rst_wtp"}, bus.out_wtp, 1);
        check({tag, "_rst_castle"}, bus.out_castle, 4'hF);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      check({tag, "_end_valid"}, bus.out_pos_valid, 0);
      check({tag, "_end_busy"}, bus.o_busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    rst = 1'b1;
    bus.i_init = 1'b0; bus.i_move_valid = 1'b0; bus.i_move_data = '0; bus.i_send = 1'b0;
    model_init();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_valid", bus.out_pos_valid, 0);
    check("rst_data", bus.out_pos_data, 0);
    check("rst_sop", bus.out_pos_sop, 0);
    check("rst_eop", bus.out_pos_eop, 0);
    check("rst_wtp", bus.out_wtp, 1);
    check("rst_castle", bus.out_castle, 4'hF);
    check("rst_epv", bus.out_ep_valid, 0);
    check("rst_ep", bus.out_ep, 0);
    rst = 1'b0;

    send_check("start", -1, -1);
    check("start_b0", beat_q[0], 4'h3);
    check("start_b4", beat_q[4], 4'h1);
    check("start_b52", beat_q[52], 4'hE);
    check("start_b63", beat_q[63], 4'hB);
    for (int k = 16; k < 48; k++) check($sformatf("start_empty%0d", k), beat_q[k], 4'h0);

    do_move(1, 4, 3, 4, 0);
    send_check("e2e4", -1, -1);
    check("e2e4_b36", beat_q[36], 4'hE);
    check("e2e4_b52", beat_q[52], 4'h0);
    check("e2e4_wtp", bus.out_wtp, 0);
    check("e2e4_epv", bus.out_ep_valid, 1);
    check("e2e4_ep", bus.out_ep, 4);

    do_move(6, 4, 4, 4, 0);
    do_move(0, 6, 2, 5, 0);
    do_move(7, 1, 5, 2, 0);
    do_move(0, 5, 3, 2, 0);
    do_move(7, 6, 5, 5, 0);
    do_move(0, 4, 0, 6, 0);
    send_check("castle", -1, -1);
    check("castle_g1", beat_q[62], 4'h9);
    check("castle_f1", beat_q[61], 4'hB);
    check("castle_e1", beat_q[60], 4'h0);
    check("castle_h1", beat_q[63], 4'h0);
    check("castle_rights", bus.out_castle, 4'b0011);

    send_check("inject", 10, -1);
    send_check("after_inject", -1, -1);

    do_init();
    do_move(1, 0, 6, 0, 0);
    do_move(6, 7, 5, 7, 0);
    do_move(6, 0, 7, 1, 3);
    send_check("promo", -1, -1);
    check("promo_b1", beat_q[1], 4'hD);
    check("promo_from", beat_q[8], 4'h0);

    do_move(6, 1, 4, 1, 0);
    @(negedge clk);
    bus.i_init = 1'b1; bus.i_send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_init = 1'b0; bus.i_send = 1'b0;
    model_init();
    seen_valid = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.out_pos_valid || bus.o_busy) seen_valid++;
    end
    check("init_send_nostream", 32'(seen_valid), 0);
    check_flags("init_send");
    send_check("init_send_board", -1, -1);

    do_move(1, 3, 3, 3, 0);
    send_check("rst_mid", -1, 20);
    @(negedge clk);
    rst = 1'b0;
    model_init();
    send_check("after_rst", -1, -1);

    for (int it = 0; it < 60; it++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 70) begin
        int cand [$];
        int sq, fr, ff, tr, tf;
        for (int r = 0; r < 8; r++)
          for (int f = 0; f < 8; f++)
            if (bd[r][f] != 4'h0 && bd[r][f][3] == m_wtp) cand.push_back(r * 8 + f);
        sq = (cand.size() == 0) ? $urandom_range(0, 63) : cand[$urandom_range(0, cand.size() - 1)];
        fr = sq / 8; ff = sq % 8;
        tr = $urandom_range(0, 7);
        if ($urandom_range(0, 2) == 0) begin
          tr = fr + (m_wtp ? 2 : -2);
          if (tr < 0 || tr > 7) tr = $urandom_range(0, 7);
        end
        tf = ($urandom_range(0, 1) == 0) ? ff : $urandom_range(0, 7);
        do_move(fr, ff, tr, tf, $urandom_range(0, 3));
      end else if (sel < 90) begin
        send_check($sformatf("rnd%0d", it), -1, -1);
      end else begin
        do_init();
      end
    end
    send_check("final", -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
